// File: rtl/vector_sequencer.sv
// Vector display sequencer: walks a vertex list in synchronous-read memory and drives the
// X/Y DAC channels with blanked moves and Bresenham lines, one point per step_en tick.
module vector_sequencer #(
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned SETTLE     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    step_en,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [2*CH_WIDTH+1:0]   mem_rdata,
  output logic [CH_WIDTH-1:0]     x_ch,
  output logic [CH_WIDTH-1:0]     y_ch,
  output logic                    blank,
  output logic                    busy,
  output logic                    frame_done
);

  // Error term and deltas carry one sign bit plus one guard bit over the channel width.
  localparam int unsigned EW    = CH_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_DRAW   = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;

  logic [2:0]          state;

  // Captured vertex
  logic                mv;
  logic                lst;
  logic [CH_WIDTH-1:0] x1;
  logic [CH_WIDTH-1:0] y1;

  // Line-walk state
  logic signed [EW-1:0] dx;
  logic signed [EW-1:0] dy;
  logic signed [EW-1:0] err;
  logic                 sx_pos;
  logic                 sy_pos;
  logic [CNT_W-1:0]     settle_cnt;

  // Setup arithmetic
  logic signed [EW-1:0] x_cur_s;
  logic signed [EW-1:0] y_cur_s;
  logic signed [EW-1:0] x1_s;
  logic signed [EW-1:0] y1_s;
  logic signed [EW-1:0] x_diff;
  logic signed [EW-1:0] y_diff;
  logic signed [EW-1:0] dx_abs;
  logic signed [EW-1:0] dy_neg;

  // Step arithmetic
  logic signed [EW:0]   e2;
  logic signed [EW:0]   dx_ext;
  logic signed [EW:0]   dy_ext;
  logic                 step_x;
  logic                 step_y;
  logic                 at_end;
  logic signed [EW-1:0] err_next;
  logic [CH_WIDTH-1:0]  x_next;
  logic [CH_WIDTH-1:0]  y_next;
  logic                 last_vertex;
  logic                 settle_done;

  // Deltas from the current beam position to the captured vertex
  always_comb begin
    x_cur_s = $signed({2'b00, x_ch});
    y_cur_s = $signed({2'b00, y_ch});
    x1_s    = $signed({2'b00, x1});
    y1_s    = $signed({2'b00, y1});
    x_diff  = x1_s - x_cur_s;
    y_diff  = y1_s - y_cur_s;
    dx_abs  = x_diff[EW-1] ? -x_diff : x_diff;
    dy_neg  = y_diff[EW-1] ? y_diff : -y_diff;
  end

  // One Bresenham step; both axis decisions use the error term from before this step
  always_comb begin
    e2       = {err, 1'b0};
    dx_ext   = {dx[EW-1], dx};
    dy_ext   = {dy[EW-1], dy};
    step_x   = (e2 >= dy_ext);
    step_y   = (e2 <= dx_ext);
    at_end   = (x_ch == x1) && (y_ch == y1);
    err_next = err;
    x_next   = x_ch;
    y_next   = y_ch;
    if (step_x) begin
      err_next = err_next + dy;
      x_next   = sx_pos ? x_ch + CH_WIDTH'(1) : x_ch - CH_WIDTH'(1);
    end
    if (step_y) begin
      err_next = err_next + dx;
      y_next   = sy_pos ? y_ch + CH_WIDTH'(1) : y_ch - CH_WIDTH'(1);
    end
  end

  // Frame termination and settle-count decode
  always_comb begin
    last_vertex = lst || (mem_addr == {ADDR_WIDTH{1'b1}});
    settle_done = (settle_cnt == CNT_W'(SETTLE - 1));
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x_ch       <= '0;
      y_ch       <= '0;
      blank      <= 1'b1;
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      frame_done <= 1'b0;
      mv         <= 1'b0;
      lst        <= 1'b0;
      x1         <= '0;
      y1         <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      sx_pos     <= 1'b0;
      sy_pos     <= 1'b0;
      settle_cnt <= '0;
    end else begin
      mem_rd_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The frame_done cycle still counts as the tail of the previous frame.
          if (start && !frame_done) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          mv    <= mem_rdata[2*CH_WIDTH+1];
          lst   <= mem_rdata[2*CH_WIDTH];
          x1    <= mem_rdata[2*CH_WIDTH-1:CH_WIDTH];
          y1    <= mem_rdata[CH_WIDTH-1:0];
          state <= S_SETUP;
        end
        S_SETUP: begin
          dx         <= dx_abs;
          dy         <= dy_neg;
          err        <= dx_abs + dy_neg;
          sx_pos     <= !x_diff[EW-1];
          sy_pos     <= !y_diff[EW-1];
          settle_cnt <= '0;
          if (mv) begin
            // Blanked jump: the beam lands on the vertex immediately, then settles.
            x_ch  <= x1;
            y_ch  <= y1;
            blank <= 1'b1;
            state <= S_SETTLE;
          end else begin
            blank <= 1'b0;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (step_en) begin
            if (at_end) begin
              state <= S_NEXT;
            end else begin
              x_ch <= x_next;
              y_ch <= y_next;
              err  <= err_next;
            end
          end
        end
        S_SETTLE: begin
          if (step_en) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
            if (settle_done) begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (last_vertex) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            blank      <= 1'b1;
            mem_addr   <= '0;
            state      <= S_IDLE;
          end else begin
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_rd_en <= 1'b1;
            state     <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: a vertex-list model pushes every expected change of
// {blank,x,y}; a negedge monitor pops and compares whenever the DUT outputs change.
module tb_vector_sequencer;

  localparam int CW = 8;
  localparam int AW = 6;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b1;
  logic          step_en = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [17:0]   mem_rdata = '0;
  logic [CW-1:0] x_ch;
  logic [CW-1:0] y_ch;
  logic          blank;
  logic          busy;
  logic          frame_done;

  logic [17:0] mem [64];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;
  bit gated = 0;
  int tcnt = 0;

  logic [16:0] exp_q[$];
  int          m_x = 0;
  int          m_y = 0;
  logic [16:0] m_prev = 17'h10000;

  vector_sequencer #(
    .CH_WIDTH   (CW),
    .ADDR_WIDTH (AW),
    .SETTLE     (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step_en    (step_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .x_ch       (x_ch),
    .y_ch       (y_ch),
    .blank      (blank),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read vertex memory
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] vtx(input bit mv, input bit lst, input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = x[7:0];
    yb = y[7:0];
    return {mv, lst, xb, yb};
  endfunction

  task automatic sb_push(input bit b, input int x, input int y);
    logic [16:0] t;
    logic [7:0]  xb;
    logic [7:0]  yb;
    xb = x[7:0];
    yb = y[7:0];
    t  = {b, xb, yb};
    if (t != m_prev) begin
      exp_q.push_back(t);
      m_prev = t;
    end
  endtask

  // Reference model of one frame; also returns the frame_done latency with step_en always high.
  task automatic model_frame(output int cyc, output int nrd, output int last);
    int a, tx, ty, dx, dy, sx, sy, err, e2, l;
    bit done;
    cyc = 0; nrd = 0; last = 0; a = 0; done = 0;
    while (!done) begin
      tx = int'(mem[a][15:8]);
      ty = int'(mem[a][7:0]);
      nrd++;
      last = a;
      if (mem[a][17]) begin
        m_x = tx;
        m_y = ty;
        sb_push(1'b1, m_x, m_y);
        cyc += 4 + ST;
      end else begin
        sb_push(1'b0, m_x, m_y);
        dx  = (tx >= m_x) ? tx - m_x : m_x - tx;
        dy  = (ty >= m_y) ? m_y - ty : ty - m_y;
        sx  = (tx >= m_x) ? 1 : -1;
        sy  = (ty >= m_y) ? 1 : -1;
        err = dx + dy;
        l   = 0;
        while (!(m_x == tx && m_y == ty) && l < 600) begin
          e2 = 2 * err;
          if (e2 >= dy) begin err += dy; m_x += sx; end
          if (e2 <= dx) begin err += dx; m_y += sy; end
          l++;
          sb_push(1'b0, m_x, m_y);
        end
        cyc += 5 + l;
      end
      if (mem[a][16] || a == 63) done = 1;
      else a++;
    end
    sb_push(1'b1, m_x, m_y);
    cyc += 1;
  endtask

  // step_en generator: every cycle, or one cycle in four when gated
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      step_en = gated ? (tcnt % 4 == 0) : 1'b1;
    end
  end

  // Output monitor / scoreboard consumer
  initial begin
    logic [16:0] cur;
    logic [16:0] prev;
    logic        sp;
    prev = '0;
    sp   = 1'b0;
    forever begin
      @(negedge clk);
      cur = {blank, x_ch, y_ch};
      if (!rst && mon_en && cur !== prev) begin
        if (!prev[16] && !cur[16] && cur[15:0] !== prev[15:0]) check("step_gate", sp, 1);
        if (exp_q.size() == 0) check("sb_qsize", exp_q.size(), 1);
        else check("sb_point", cur, exp_q.pop_front());
      end
      prev = cur;
      sp   = step_en;
    end
  end

  task automatic run_frame(input string nm, input int inject_at, input bit start_at_done);
    int exp_k, exp_rd, exp_last, k, n_rd, last_addr;
    bit seen;
    model_frame(exp_k, exp_rd, exp_last);
    k = 0; n_rd = 0; last_addr = -1; seen = 0;
    @(negedge clk);
    start = 1'b1;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      start = (k == inject_at);
      if (k == 1) begin
        check({nm, "_busy"}, busy, 1);
        check({nm, "_rd_lat"}, mem_rd_en, 1);
        check({nm, "_addr0"}, mem_addr, 0);
      end
      if (mem_rd_en) begin
        n_rd++;
        last_addr = mem_addr;
      end
      if (frame_done) begin
        seen = 1;
        check({nm, "_busy_fall"}, busy, 0);
      end
    end
    check({nm, "_done_seen"}, seen, 1);
    if (!gated) check({nm, "_done_lat"}, k, exp_k);
    check({nm, "_rd_count"}, n_rd, exp_rd);
    check({nm, "_last_addr"}, last_addr, exp_last);
    start = start_at_done;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_done_pulse"}, frame_done, 0);
    check({nm, "_idle"}, {busy, mem_rd_en}, 0);
    check({nm, "_addr_ret"}, mem_addr, 0);
    check({nm, "_sb_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    bit saw_done;

    // Reset wins over start
    repeat (2) begin
      @(negedge clk);
      check("rst_xy", {x_ch, y_ch}, 0);
      check("rst_flags", {blank, busy, mem_rd_en, frame_done}, 4'b1000);
      check("rst_addr", mem_addr, 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, mem_rd_en}, 0);
    mon_en = 1;

    // Single blanked move, start offered again in the frame_done cycle
    mem[0] = vtx(1, 1, 10, 20);
    run_frame("move", 0, 1'b1);

    // Horizontal line, start pulsed while busy
    mem[0] = vtx(1, 0, 0, 0);
    mem[1] = vtx(0, 1, 5, 0);
    run_frame("horiz", 6, 1'b0);

    // Steep line and a negative-direction line
    mem[0] = vtx(1, 0, 0, 0);
    mem[1] = vtx(0, 1, 3, 7);
    run_frame("steep", 0, 1'b0);
    check("steep_end", {x_ch, y_ch}, {8'd3, 8'd7});
    mem[0] = vtx(1, 0, 200, 200);
    mem[1] = vtx(0, 1, 190, 195);
    run_frame("neg", 0, 1'b0);
    check("neg_end", {x_ch, y_ch}, {8'd190, 8'd195});

    // Zero-length draw exits on its first tick
    mem[0] = vtx(0, 1, 190, 195);
    run_frame("zero", 0, 1'b0);

    // Gated stepping with a trailing zero-length vertex
    gated  = 1;
    mem[0] = vtx(1, 0, 20, 30);
    mem[1] = vtx(0, 0, 25, 40);
    mem[2] = vtx(0, 1, 25, 40);
    run_frame("gated", 0, 1'b0);
    gated = 0;

    // Full list with no last bit ends at the final address
    for (int i = 0; i < 64; i++) mem[i] = vtx(1, 0, i, 2 * i);
    run_frame("full", 0, 1'b0);

    // Reset in the middle of a draw aborts without frame_done
    mon_en = 0;
    mem[0] = vtx(1, 0, 0, 0);
    mem[1] = vtx(0, 1, 100, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_lit", blank, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_xy", {x_ch, y_ch}, 0);
    check("mid_rst_flags", {blank, busy, mem_rd_en, frame_done}, 4'b1000);
    rst = 1'b0;
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done) saw_done = 1;
    end
    check("mid_no_done", saw_done, 0);
    check("mid_idle", busy, 0);
    exp_q.delete();
    m_x = 0;
    m_y = 0;
    m_prev = 17'h10000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
